// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: small byte FIFO feeding a baud-tick driven
// start/data/parity/stop serialiser with registered tx line.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q;
  logic                 baud_q;
  logic                 tick;
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [PW:0]          count_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rd_data;
  logic [2:0]           bit_cnt_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 tx_done_q;
  logic                 overflow_q;
  logic                 push;
  logic                 pop;
  logic                 rd_parity;

  assign tick      = baud_in & ~baud_q;
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = wr_en & ~full;
  assign pop       = tick & ~empty & ((state_q == IDLE) || (state_q == STOP));
  assign rd_data   = mem_q[rd_ptr_q];
  assign rd_parity = (^rd_data) ^ (PARITY_ODD != 0);

  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign tx_done  = tx_done_q;
  assign busy     = (state_q != IDLE);

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      baud_q <= baud_in;
      if (wr_en & full) overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            tx_q <= 1'b1;
            if (pop) begin
              shift_q   <= rd_data;
              bit_cnt_q <= '0;
              parity_q  <= rd_parity;
              tx_q      <= 1'b0;
              state_q   <= START;
            end
          end
          START: begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
          DATA: begin
            if (bit_cnt_q == 3'(DATA_BITS-1)) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end
          PARITY: begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
          STOP: begin
            tx_done_q <= 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift_q   <= rd_data;
              bit_cnt_q <= '0;
              parity_q  <= rd_parity;
              tx_q      <= 1'b0;
              state_q   <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (default, even and
// odd parity instances sharing one stimulus).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_in = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic full, empty, overflow, tx, busy, tx_done;
  logic full_e, empty_e, overflow_e, tx_e, busy_e, tx_done_e;
  logic full_o, empty_o, overflow_o, tx_o, busy_o, tx_done_o;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int bcnt = 0;
  bit baud_en = 1'b0;
  bit baud_force = 1'b1;

  uart_tx u_dut (
    .clk(clk), .rst(rst), .baud_in(baud_in), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .baud_in(baud_in), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_e), .empty(empty_e), .overflow(overflow_e), .tx(tx_e), .busy(busy_e), .tx_done(tx_done_e)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .baud_in(baud_in), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o), .empty(empty_o), .overflow(overflow_o), .tx(tx_o), .busy(busy_o), .tx_done(tx_done_o)
  );

  always #5 clk = ~clk;

  // Baud generator: 8 clk period, 4 high / 4 low, or a forced static level.
  always @(negedge clk) begin
    if (baud_en) begin
      bcnt = (bcnt + 1) % 8;
      baud_in = (bcnt < 4);
    end else begin
      baud_in = baud_force;
    end
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    n_vec++; if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (tx_done !== 1'b0)  begin n_err++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_vec++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_basic_frame();
    logic [9:0] exp;
    bit got;
    int d0;
    exp = 10'b0101001011;
    baud_en = 1'b1;
    apply_reset();
    d0 = done_cnt;
    write_byte(8'hA5);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL basic_start: tx=%b never fell within 40 clk", tx); return; end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_hi: got %b want 1", busy); end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 8; c++) begin
        n_vec++;
        if (tx !== exp[9-k]) begin n_err++; $display("FAIL basic_bit%0d_clk%0d: tx=%b want %b", k, c, tx, exp[9-k]); end
        @(posedge clk); #1;
      end
    end
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL basic_tx_done: got %b want 1", tx_done); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL basic_busy_lo: got %b want 0", busy); end
    repeat (2) @(posedge clk); #1;
    n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_parity();
    logic [10:0] exp_e;
    logic [10:0] exp_o;
    bit got;
    exp_e = 11'b01010010101;
    exp_o = 11'b01010010111;
    baud_en = 1'b1;
    apply_reset();
    write_byte(8'hA5);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tx_e === 1'b0) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL parity_start: tx_e=%b never fell within 40 clk", tx_e); return; end
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 8; c++) begin
        n_vec++;
        if (tx_e !== exp_e[10-k]) begin n_err++; $display("FAIL even_bit%0d_clk%0d: tx=%b want %b", k, c, tx_e, exp_e[10-k]); end
        n_vec++;
        if (tx_o !== exp_o[10-k]) begin n_err++; $display("FAIL odd_bit%0d_clk%0d: tx=%b want %b", k, c, tx_o, exp_o[10-k]); end
        @(posedge clk); #1;
      end
    end
    n_vec++; if (tx_done_e !== 1'b1) begin n_err++; $display("FAIL even_tx_done: got %b want 1", tx_done_e); end
    n_vec++; if (busy_o !== 1'b0)    begin n_err++; $display("FAIL odd_busy_lo: got %b want 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp;
    bit got;
    int d0;
    exp = {10'b0000000001, 10'b0111111111, 10'b0001111001};
    baud_en = 1'b1;
    apply_reset();
    d0 = done_cnt;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk); wr_data = 8'hFF;
    @(negedge clk); wr_data = 8'h3C;
    @(negedge clk); wr_en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL b2b_start: tx=%b never fell within 40 clk", tx); return; end
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < 8; c++) begin
        n_vec++;
        if (tx !== exp[29-k]) begin n_err++; $display("FAIL b2b_bit%0d_clk%0d: tx=%b want %b", k, c, tx, exp[29-k]); end
        @(posedge clk); #1;
      end
    end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL b2b_busy_lo: got %b want 0", busy); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty); end
    repeat (2) @(posedge clk); #1;
    n_vec++; if (done_cnt - d0 !== 3) begin n_err++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
  endtask

  task automatic test_overflow();
    int d0;
    baud_en = 1'b0;
    baud_force = 1'b0;
    apply_reset();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_vec++; if (full !== 1'b1)     begin n_err++; $display("FAIL ovf_full_after4: got %b want 1", full); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      wr_en = 1'b1;
      wr_data = 8'(16 + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL ovf_idle: busy=%b want 0", busy); end
    baud_en = 1'b1;
    repeat (450) @(posedge clk); #1;
    n_vec++; if (done_cnt - d0 !== 4) begin n_err++; $display("FAIL ovf_frames: got %0d want 4", done_cnt - d0); end
    n_vec++; if (overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_vec++; if (empty !== 1'b1)      begin n_err++; $display("FAIL ovf_empty: got %b want 1", empty); end
  endtask

  task automatic test_baud_high_reset();
    baud_en = 1'b0;
    baud_force = 1'b1;
    apply_reset();
    write_byte(8'h55);
    repeat (20) @(posedge clk); #1;
    n_vec++; if (tx !== 1'b1)    begin n_err++; $display("FAIL bh_no_start_tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL bh_no_start_busy: got %b want 0", busy); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL bh_queued: empty=%b want 0", empty); end
    @(negedge clk); baud_force = 1'b0;
    @(negedge clk); baud_force = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (tx !== 1'b0)   begin n_err++; $display("FAIL bh_start_tx: got %b want 0", tx); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bh_start_busy: got %b want 1", busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp;
    bit got;
    exp = 10'b0100000011;
    baud_en = 1'b1;
    apply_reset();
    write_byte(8'hA5);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL mid_start: tx=%b never fell within 40 clk", tx); return; end
    repeat (28) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++; if (tx !== 1'b1)    begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
    @(negedge clk);
    rst = 1'b1;
    write_byte(8'h81);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL mid_restart: tx=%b never fell within 40 clk", tx); return; end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 8; c++) begin
        n_vec++;
        if (tx !== exp[9-k]) begin n_err++; $display("FAIL mid_bit%0d_clk%0d: tx=%b want %b", k, c, tx, exp[9-k]); end
        @(posedge clk); #1;
      end
    end
    n_vec++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL mid_tx_done: got %b want 1", tx_done); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_baud_high_reset();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
